// File: rtl/l2_norm_ctrl.sv
// Vector L2-norm controller: accumulates the sum of squares of 8-bit beats, then
// takes a 10-cycle bit-serial square root. Optional L2_NORM_ROUND_EN rounds out_norm.
module l2_norm_ctrl #(
    parameter int VEC_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [19:0] out_sumsq,
    output logic [9:0]  out_norm,
    output logic [4:0]  out_len,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {ACC, SQRT, OUT} state_t;

    state_t      state, state_nxt;
    logic [19:0] acc;
    logic [19:0] rad;
    logic [4:0]  count;
    logic [3:0]  iter;
    logic [11:0] rem;
    logic [9:0]  root;

    logic        accept, vec_done;
    logic [15:0] sq;
    logic [13:0] rem_sh, trial;
    logic        ge;
    logic [11:0] rem_nxt;
    logic [9:0]  root_nxt, norm_fin;

    assign in_ready  = (state == ACC);
    assign out_valid = (state == OUT);
    assign busy      = (state != ACC);
    assign accept    = in_valid && in_ready;
    assign vec_done  = accept && (in_last || count == 5'(VEC_MAX - 1));
    assign sq        = in_data * in_data;

    // One restoring step: bring down the next two radicand bits, try subtracting 4r+1.
    always_comb begin
        rem_sh   = {rem, rad[19:18]};
        trial    = {2'b00, root, 2'b01};
        ge       = (rem_sh >= trial);
        rem_nxt  = ge ? 12'(rem_sh - trial) : 12'(rem_sh);
        root_nxt = {root[8:0], ge};
`ifdef L2_NORM_ROUND_EN
        norm_fin = (rem_nxt > {2'b00, root_nxt}) ? root_nxt + 10'd1 : root_nxt;
`else
        norm_fin = root_nxt;
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (vec_done) state_nxt = SQRT;
            SQRT:    if (iter == 4'd10) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ACC;
            acc       <= '0;
            count     <= '0;
            iter      <= '0;
            rad       <= '0;
            rem       <= '0;
            root      <= '0;
            out_sumsq <= '0;
            out_norm  <= '0;
            out_len   <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ACC: begin
                    iter <= '0;
                    if (accept) begin
                        acc   <= acc + 20'(sq);
                        count <= count + 5'd1;
                        if (vec_done) err <= !in_last;
                    end
                end
                SQRT: begin
                    iter <= iter + 4'd1;
                    // iter 0 loads the radicand; iters 1..10 each produce one root bit
                    if (iter == 4'd0) begin
                        rad  <= acc;
                        rem  <= '0;
                        root <= '0;
                    end else begin
                        rad  <= {rad[17:0], 2'b00};
                        rem  <= rem_nxt;
                        root <= root_nxt;
                    end
                    if (iter == 4'd10) begin
                        out_sumsq <= acc;
                        out_norm  <= norm_fin;
                        out_len   <= count;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        acc   <= '0;
                        count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_norm_ctrl.sv
// Randomized and directed bench for l2_norm_ctrl against a plain-arithmetic model.
module tb_l2_norm_ctrl;
    localparam int VM = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] out_sumsq;
    logic [9:0]  out_norm;
    logic [4:0]  out_len;
    logic        err;
    logic        busy;

    l2_norm_ctrl #(.VEC_MAX(VM)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_sumsq(out_sumsq), .out_norm(out_norm),
        .out_len(out_len), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int sumsq; int norm; int len; int err;} res_t;

    res_t expq[$];
    int   checks = 0, failures = 0;
    int   edge_cnt = 0, final_edge = 0;
    int   or_mode = 0;
    int   cur_sum = 0, cur_len = 0;
    bit   prev_valid = 0, prev_hs = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic res_t model(int s, int len, int e);
        res_t m;
        int r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
`ifdef L2_NORM_ROUND_EN
        if (s - r * r > r) r++;
`endif
        m.sumsq = s; m.norm = r; m.len = len; m.err = e;
        return m;
    endfunction

    // Every cycle a result is presented it must match the oldest pending vector.
    always @(negedge clk) begin
        if (!reset) begin
            prev_valid = 0;
            prev_hs    = 0;
        end else begin
            if (prev_hs) begin
                chk("post_hs_out_valid", out_valid, 0);
                chk("post_hs_in_ready", in_ready, 1);
                chk("post_hs_busy", busy, 0);
            end
            prev_hs = 0;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk("spurious_out_valid", out_valid, 0);
                end else begin
                    chk("sumsq", out_sumsq, expq[0].sumsq);
                    chk("norm", out_norm, expq[0].norm);
                    chk("len", out_len, expq[0].len);
                    chk("err", err, expq[0].err);
                    chk("in_ready_in_out", in_ready, 0);
                    chk("busy_in_out", busy, 1);
                    if (!prev_valid) chk("latency", edge_cnt - final_edge, 11);
                    if (out_ready) begin
                        prev_hs = 1;
                        void'(expq.pop_front());
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    task automatic send(int d, bit last);
        int t = 0;
        in_valid = 1'b1;
        in_data  = 8'(d);
        in_last  = last;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cur_sum += d * d;
        cur_len++;
        if (last || cur_len == VM) begin
            expq.push_back(model(cur_sum, cur_len, last ? 0 : 1));
            final_edge = edge_cnt;
            cur_sum = 0;
            cur_len = 0;
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_data = 8'($urandom);
            in_last = 1'($urandom);
        end
    endtask

    task automatic expect_res(string nm, int s, int n, int l, int e);
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 60) begin @(negedge clk); t++; end
        if (!out_valid) begin
            chk({nm, "_timeout"}, out_valid, 1);
        end else begin
            chk({nm, "_sumsq"}, out_sumsq, s);
            chk({nm, "_norm"}, out_norm, n);
            chk({nm, "_len"}, out_len, l);
            chk({nm, "_err"}, err, e);
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((expq.size() != 0 || out_valid) && t < 500) begin @(negedge clk); t++; end
        chk("drain_pending", expq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        res_t m;
        int rel_edge, len, kind, d;
        bit trunc;

        m = model(25, 2, 0);      chk("pin_model_25", m.norm, 5);
        m = model(1040400, 16, 0); chk("pin_model_1040400", m.norm, 1020);
        m = model(16, 16, 1);     chk("pin_model_16", m.norm, 4);
`ifdef L2_NORM_ROUND_EN
        m = model(8, 2, 0);       chk("pin_model_8", m.norm, 3);
        m = model(99, 1, 0);      chk("pin_model_99", m.norm, 10);
`else
        m = model(8, 2, 0);       chk("pin_model_8", m.norm, 2);
        m = model(99, 1, 0);      chk("pin_model_99", m.norm, 9);
`endif

        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sumsq", out_sumsq, 0);
        chk("rst_norm", out_norm, 0);
        chk("rst_len", out_len, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        or_mode = 0;
        idle(2);

        send(3, 0); send(4, 1);
        expect_res("v34", 25, 5, 2, 0);

        for (int i = 0; i < 16; i++) send(255, i == 15);
        expect_res("v255", 1040400, 1020, 16, 0);

        for (int i = 0; i < 16; i++) send(1, 0);
        expect_res("trunc", 16, 4, 16, 1);
        send(7, 1);
        expect_res("after_trunc", 49, 7, 1, 0);

        send(0, 1);
        expect_res("zero", 0, 0, 1, 0);

        send(2, 0); send(2, 1);
`ifdef L2_NORM_ROUND_EN
        expect_res("v22", 8, 3, 2, 0);
`else
        expect_res("v22", 8, 2, 2, 0);
`endif
        drain();

        // hold the consumer off for five cycles while a result is pending
        or_mode = 2;
        idle(2);
        send(6, 0); send(8, 1);
        begin
            int t = 0;
            @(negedge clk);
            while (!out_valid && t < 60) begin @(negedge clk); t++; end
        end
        repeat (5) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
            chk("bp_sumsq", out_sumsq, 100);
            chk("bp_norm", out_norm, 10);
            @(negedge clk);
        end
        or_mode = 0;
        begin
            int t = 0;
            while (out_valid && t < 20) begin @(negedge clk); t++; end
        end
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_busy", busy, 0);
        chk("bp_hold_sumsq", out_sumsq, 100);
        @(posedge clk); #1;

        // reset lands in the middle of the root iterations
        send(1, 0); send(2, 1);
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b0;
        expq.delete();
        cur_sum = 0;
        cur_len = 0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sumsq", out_sumsq, 0);
        chk("mid_rst_norm", out_norm, 0);
        chk("mid_rst_len", out_len, 0);
        chk("mid_rst_err", err, 0);
        @(negedge clk);
        reset = 1'b1;
        rel_edge = edge_cnt;
        send(5, 1);
        chk("first_edge_accept", final_edge - rel_edge, 1);
        expect_res("after_rst", 25, 5, 1, 0);
        drain();

        or_mode = 1;
        for (int v = 0; v < 40; v++) begin
            len   = $urandom_range(1, VM);
            trunc = ($urandom_range(0, 3) == 0);
            if (trunc) len = VM;
            kind  = $urandom_range(0, 3);
            for (int i = 0; i < len; i++) begin
                case (kind)
                    0:       d = 0;
                    1:       d = 255 - $urandom_range(0, 3);
                    default: d = $urandom_range(0, 255);
                endcase
                send(d, !trunc && (i == len - 1));
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/l2_norm_ctrl.md
L2_NORM_CTRL -- requirements
Module: l2_norm_ctrl

Interface
REQ-001 SHALL have parameter VEC_MAX, default 16, maximum beats per vector; legal range 1..16 (keeps 20-bit sum exact).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  sample offered.
REQ-005 SHALL have port in_data  input  8  unsigned vector element.
REQ-006 SHALL have port in_last  input  1  final element of the vector.
REQ-007 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port out_sumsq  output  20  sum of squares of the vector.
REQ-011 SHALL have port out_norm  output  10  integer square root of out_sumsq.
REQ-012 SHALL have port out_len  output  5  number of elements accumulated (1..16).
REQ-013 SHALL have port err  output  1  vector truncated at VEC_MAX without in_last.
REQ-014 SHALL have port busy  output  1  high in SQRT or OUT state.

Function
REQ-015 SHALL implement FSM states ACC, SQRT, OUT; ACC is the only state with in_ready=1.
REQ-016 A beat SHALL be accepted when in_valid && in_ready; on that edge acc <= acc + in_data*in_data (20-bit, no wrap possible) and count increments.
REQ-017 ACC->SQRT SHALL occur on the accepting edge when in_last=1 or count reaches VEC_MAX; err latches 1 if in_last=0 in the latter case, else 0.
REQ-018 SQRT SHALL run a restoring bit-serial square root, one result bit per cycle, MSB first, exactly 10 cycles.
REQ-019 SQRT->OUT SHALL occur after the 10th iteration; out_valid rises 11 cycles after the edge accepting the final beat.
REQ-020 In OUT, out_valid, out_sumsq, out_norm, out_len, err SHALL hold stable until out_valid && out_ready.
REQ-021 On the output handshake edge SHALL return to ACC with acc=0, count=0; in_ready=1 from the next cycle (no same-cycle accept in OUT).
REQ-022 out_valid SHALL deassert on the cycle after the handshake; result outputs SHALL retain values until the next result.
REQ-023 in_data/in_last SHALL be ignored when in_ready=0; in_valid without in_ready SHALL not alter state.
REQ-024 A single-element vector SHALL be legal; all-zero data SHALL yield out_sumsq=0, out_norm=0.

Reset
REQ-025 reset low SHALL asynchronously force state ACC, acc=0, count=0, out_valid=0, out_sumsq=0, out_norm=0, out_len=0, err=0, busy=0, in_ready=1.
REQ-026 reset asserted in any state (including mid-SQRT) SHALL discard the partial vector; no result is emitted for it.
REQ-027 After reset deasserts, the first rising edge SHALL be able to accept a beat.

Configuration
REQ-028 Macro L2_NORM_ROUND_EN SHALL select rounding of out_norm.
REQ-029 With L2_NORM_ROUND_EN defined, out_norm SHALL be floor root r plus 1 when (out_sumsq - r*r) > r; latency unchanged.
REQ-030 Without L2_NORM_ROUND_EN, out_norm SHALL be floor(sqrt(out_sumsq)).

Verification
REQ-031 Beats {3, 4+last}, out_ready=1 -> out_sumsq=25, out_norm=5, out_len=2, err=0, out_valid 11 cycles after beat 2.
REQ-032 16 beats of 255, last on 16th -> out_sumsq=1040400, out_norm=1020, out_len=16, err=0.
REQ-033 VEC_MAX=16, 16 beats of 1 with in_last=0 -> err=1, out_len=16, out_sumsq=16, out_norm=4; 17th beat after handshake starts a new vector.
REQ-034 Backpressure: out_ready low 5 cycles -> out_valid and outputs stable, in_ready=0, busy=1; handshake -> in_ready=1 next cycle, busy=0.
REQ-035 Beats {2, 2+last} -> out_sumsq=8, out_norm=2 without L2_NORM_ROUND_EN, 3 with it.
REQ-036 reset pulsed during SQRT iteration 5 -> all outputs zero, in_ready=1, no out_valid; next vector {5+last} -> out_norm=5.
